// File: rtl/dotprod_lanes.sv
// dotprod_lanes: LANES-wide signed dot product over a windowed pair of banked arrays.
// Define DOTPROD_SAT_EN for a saturating accumulator with a sticky ovf flag.
module dotprod_lanes #(
  parameter int DATA_W = 27,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10,
  parameter int LANES  = 4,
  parameter int ACC_W  = 64
) (
  input  logic                     clk,
  input  logic                     r_enable,
  input  logic [ADDR_W-1:0]        init_i,
  input  logic [ADDR_W:0]          init_len,
  input  logic signed [ACC_W-1:0]  init_acc,
  input  logic                     controlArr,
  input  logic                     controlArrWEnable_a,
  input  logic                     controlArrWEnable_b,
  input  logic [ADDR_W-1:0]        controlArrAddr_a,
  input  logic [ADDR_W-1:0]        controlArrAddr_b,
  input  logic signed [DATA_W-1:0] controlArrWData_a,
  input  logic signed [DATA_W-1:0] controlArrWData_b,
  output logic signed [DATA_W-1:0] controlArrRData_a,
  output logic signed [DATA_W-1:0] controlArrRData_b,
  output logic                     w_enable,
  output logic signed [ACC_W-1:0]  result,
  output logic                     busy,
  output logic                     ovf
);
  localparam int ROWS = DEPTH / LANES;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int PW   = 2 * DATA_W;
  localparam int EW   = ADDR_W + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_state_nx;

  logic [EW-1:0] w_i0, w_sum, w_end, w_frow, w_lrow, w_rows;
  logic          w_empty;
  logic [EW-1:0] r_lo, r_end, w_base;
  logic [RW-1:0] r_row, r_last, w_eng_row;
  logic [ADDR_W:0] r_left;
  logic r_v1, r_v2, r_replay;
  logic w_stall, w_issue, w_busy;
  logic [LANES-1:0] r_m1, w_mask;
  logic signed [PW-1:0] r_p [LANES];
  logic signed [PW-1:0] w_p [LANES];
  logic signed [ACC_W-1:0] r_acc, w_lsum, w_acc_nx;

  logic signed [DATA_W-1:0] r_mem_a [LANES][ROWS];
  logic signed [DATA_W-1:0] r_mem_b [LANES][ROWS];
  logic signed [DATA_W-1:0] r_qa [LANES];
  logic signed [DATA_W-1:0] r_qb [LANES];
  logic w_ina, w_inb, r_oora, r_oorb;
  logic [ADDR_W-1:0] w_bka, w_bkb, r_sela, r_selb;
  logic [RW-1:0] w_srow_a, w_srow_b, w_row_a, w_row_b;

  always_comb begin
    w_i0    = EW'(init_i);
    w_sum   = w_i0 + EW'(init_len);
    w_end   = (w_sum > EW'(DEPTH)) ? EW'(DEPTH) : w_sum;
    w_empty = (init_len == '0) || (w_i0 >= EW'(DEPTH));
    w_frow  = w_i0 / EW'(LANES);
    w_lrow  = (w_end - EW'(1)) / EW'(LANES);
    w_rows  = w_empty ? '0 : w_lrow - w_frow + EW'(1);
  end

  assign w_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_stall   = controlArr | r_replay;
  assign w_eng_row = r_replay ? r_last : r_row;

  assign w_ina    = {1'b0, controlArrAddr_a} < (ADDR_W+1)'(DEPTH);
  assign w_inb    = {1'b0, controlArrAddr_b} < (ADDR_W+1)'(DEPTH);
  assign w_bka    = controlArrAddr_a % ADDR_W'(LANES);
  assign w_bkb    = controlArrAddr_b % ADDR_W'(LANES);
  assign w_srow_a = w_ina ? RW'(controlArrAddr_a / ADDR_W'(LANES)) : '0;
  assign w_srow_b = w_inb ? RW'(controlArrAddr_b / ADDR_W'(LANES)) : '0;
  assign w_row_a  = controlArr ? w_srow_a : w_eng_row;
  assign w_row_b  = controlArr ? w_srow_b : w_eng_row;

  // Single-port banks: side port owns the address while controlArr is high.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (controlArr && controlArrWEnable_a && w_ina && w_bka == ADDR_W'(j))
        r_mem_a[j][w_srow_a] <= controlArrWData_a;
      if (controlArr && controlArrWEnable_b && w_inb && w_bkb == ADDR_W'(j))
        r_mem_b[j][w_srow_b] <= controlArrWData_b;
      r_qa[j] <= r_mem_a[j][w_row_a];
      r_qb[j] <= r_mem_b[j][w_row_b];
    end
    r_sela <= w_bka;
    r_selb <= w_bkb;
    r_oora <= !w_ina;
    r_oorb <= !w_inb;
  end

  always_comb begin
    controlArrRData_a = '0;
    controlArrRData_b = '0;
    for (int j = 0; j < LANES; j++) begin
      if (!r_oora && r_sela == ADDR_W'(j)) controlArrRData_a = r_qa[j];
      if (!r_oorb && r_selb == ADDR_W'(j)) controlArrRData_b = r_qb[j];
    end
  end

  assign w_base = EW'(r_row) * EW'(LANES);

  always_comb begin
    w_mask = '0;
    w_lsum = '0;
    for (int j = 0; j < LANES; j++) begin
      w_mask[j] = (w_base + EW'(j) >= r_lo) && (w_base + EW'(j) < r_end);
      w_p[j]    = r_m1[j] ? PW'(r_qa[j]) * PW'(r_qb[j]) : '0;
      w_lsum    = w_lsum + ACC_W'(r_p[j]);
    end
  end

`ifdef DOTPROD_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W:0] w_wide;
  logic           w_clamp, r_ovf;

  always_comb begin
    w_wide   = {r_acc[ACC_W-1], r_acc} + {w_lsum[ACC_W-1], w_lsum};
    w_clamp  = w_wide[ACC_W] ^ w_wide[ACC_W-1];
    w_acc_nx = w_wide[ACC_W-1:0];
    if (w_clamp) w_acc_nx = w_wide[ACC_W] ? ACC_MIN : ACC_MAX;
  end

  always_ff @(posedge clk) begin
    if (r_enable) r_ovf <= 1'b0;
    else if (!w_stall && r_v2 && w_clamp) r_ovf <= 1'b1;
  end
  assign ovf = r_ovf;
`else
  assign w_acc_nx = r_acc + w_lsum;
  assign ovf      = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_issue    = 1'b0;
    if (!w_stall) begin
      unique case (r_state)
        S_IDLE:  w_state_nx = S_RUN;
        S_RUN: begin
          w_issue = (r_left != '0);
          if (r_left <= (ADDR_W+1)'(1)) w_state_nx = S_DRAIN;
        end
        S_DRAIN: if (!r_v1) w_state_nx = S_DONE;
        default: w_state_nx = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_enable) r_state <= S_IDLE;
    else          r_state <= w_state_nx;
  end

  // A stall is always followed by one replay cycle re-reading the last row.
  always_ff @(posedge clk) begin
    if (r_enable) begin
      r_lo     <= w_i0;
      r_end    <= w_end;
      r_row    <= RW'(w_frow);
      r_last   <= RW'(w_frow);
      r_left   <= (ADDR_W+1)'(w_rows);
      r_acc    <= init_acc;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_replay <= 1'b0;
    end else begin
      r_replay <= controlArr && w_busy;
      if (!w_stall) begin
        r_v1 <= w_issue;
        r_v2 <= r_v1;
        r_p  <= w_p;
        if (w_issue) begin
          r_m1   <= w_mask;
          r_last <= r_row;
          r_row  <= r_row + RW'(1);
          r_left <= r_left - (ADDR_W+1)'(1);
        end
        if (r_v2) r_acc <= w_acc_nx;
      end
    end
  end

  assign busy     = w_busy;
  assign w_enable = (r_state == S_DONE);
  assign result   = w_enable ? r_acc : '0;
endmodule

// File: tb/tb_dotprod_lanes.sv
// tb_dotprod_lanes: directed and random windows against an array model,
// plus stall, mid-run reset and accumulator overflow.
module tb_dotprod_lanes;
  localparam int DW = 27;
  localparam int DEPTH = 1000;
  localparam int AW = 10;
  localparam int AC = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r_enable, controlArr, we_a, we_b;
  logic [AW-1:0] init_i, addr_a, addr_b;
  logic [AW:0] init_len;
  logic signed [AC-1:0] init_acc, result;
  logic signed [DW-1:0] wd_a, wd_b, rd_a, rd_b;
  logic w_enable, busy, ovf;

  longint ma[DEPTH];
  longint mb[DEPTH];
  int n_vec = 0;
  int n_bad = 0;

  dotprod_lanes dut (
    .clk(clk), .r_enable(r_enable),
    .init_i(init_i), .init_len(init_len), .init_acc(init_acc),
    .controlArr(controlArr),
    .controlArrWEnable_a(we_a), .controlArrWEnable_b(we_b),
    .controlArrAddr_a(addr_a), .controlArrAddr_b(addr_b),
    .controlArrWData_a(wd_a), .controlArrWData_b(wd_b),
    .controlArrRData_a(rd_a), .controlArrRData_b(rd_b),
    .w_enable(w_enable), .result(result), .busy(busy), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int k, input longint va, input longint vb);
    controlArr = 1'b1;
    we_a = 1'b1;
    we_b = 1'b1;
    addr_a = AW'(k);
    addr_b = AW'(k);
    wd_a = DW'(va);
    wd_b = DW'(vb);
    step();
    we_a = 1'b0;
    we_b = 1'b0;
    controlArr = 1'b0;
    if (k < DEPTH) begin
      ma[k] = va;
      mb[k] = vb;
    end
  endtask

  function automatic longint model(input int i0, input int n, input longint a0);
    longint s = a0;
    for (int k = i0; k < i0 + n && k < DEPTH; k++) s += ma[k] * mb[k];
    return s;
  endfunction

  function automatic int rows_in(input int i0, input int n);
    int cnt = 0;
    int prev = -1;
    for (int k = i0; k < i0 + n && k < DEPTH; k++)
      if (k / 4 != prev) begin
        cnt++;
        prev = k / 4;
      end
    return cnt;
  endfunction

  task automatic start(input int i0, input int n, input longint a0);
    r_enable = 1'b1;
    init_i = AW'(i0);
    init_len = (AW+1)'(n);
    init_acc = a0;
    step();
    r_enable = 1'b0;
  endtask

  task automatic finish_run(input int i0, input int n, input longint er,
                            input string tag, input int st, input int sl);
    int el;
    int cyc;
    el = rows_in(i0, n) + 3 + ((sl > 0) ? sl + 1 : 0);
    cyc = 0;
    while (w_enable !== 1'b1 && cyc < el + 40) begin
      controlArr = (sl > 0) && cyc >= st && cyc < st + sl;
      we_a = controlArr && cyc == st;
      addr_a = '0;
      wd_a = 27'sd12345;
      step();
      cyc++;
    end
    controlArr = 1'b0;
    we_a = 1'b0;
    chk({tag, "_lat"}, 64'(cyc), 64'(el));
    chk({tag, "_res"}, result, er);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    if (sl > 0) ma[0] = 12345;
  endtask

  initial begin
    logic signed [DW-1:0] t;
    longint er;
    int i0, n, k;
    r_enable = 1'b1;
    controlArr = 1'b0;
    we_a = 1'b0;
    we_b = 1'b0;
    addr_a = '0;
    addr_b = '0;
    wd_a = '0;
    wd_b = '0;
    init_i = '0;
    init_len = '0;
    init_acc = '0;
    repeat (3) step();
    chk("rst_we", 64'(w_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res", result, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);

    for (int j = 0; j < DEPTH; j++) put(j, j, 1);
    start(0, 1000, 5);
    er = model(0, 1000, 5);
    finish_run(0, 1000, er, "full", 0, 0);
    step();
    chk("full_hold_we", 64'(w_enable), 64'd1);
    chk("full_hold_res", result, er);

    r_enable = 1'b1;
    for (int j = 0; j < DEPTH; j++) put(j, j, j);
    start(3, 6, 0);
    finish_run(3, 6, model(3, 6, 0), "unal", 0, 0);
    start(0, 0, -7);
    finish_run(0, 0, model(0, 0, -7), "empty", 0, 0);
    start(998, 10, 0);
    finish_run(998, 10, model(998, 10, 0), "clamp", 0, 0);

    r_enable = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      longint va;
      t = DW'($urandom);
      va = longint'(t);
      t = DW'($urandom);
      put(j, va, longint'(t));
    end

    for (int j = 0; j < 4; j++) begin
      k = $urandom_range(0, DEPTH - 1);
      controlArr = 1'b1;
      addr_a = AW'(k);
      addr_b = AW'(k);
      step();
      chk("rd_a", 64'(rd_a), 64'(ma[k]));
      chk("rd_b", 64'(rd_b), 64'(mb[k]));
    end
    addr_a = AW'(1005);
    addr_b = AW'(1020);
    step();
    chk("rd_a_oor", 64'(rd_a), 64'd0);
    chk("rd_b_oor", 64'(rd_b), 64'd0);
    controlArr = 1'b0;

    for (int j = 0; j < 6; j++) begin
      i0 = $urandom_range(0, 1023);
      n = $urandom_range(0, 1100);
      if (j == 0) i0 = $urandom_range(0, 40);
      er = longint'({$urandom, $urandom});
      er = er >>> 4;
      start(i0, n, er);
      finish_run(i0, n, model(i0, n, er), "rnd", 0, 0);
    end

    start(0, 200, -3);
    finish_run(0, 200, model(0, 200, -3), "stall", 20, 4);

    start(0, 400, 1);
    repeat (10) step();
    chk("mid_busy", 64'(busy), 64'd1);
    start(5, 300, 77);
    chk("abort_we", 64'(w_enable), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    finish_run(5, 300, model(5, 300, 77), "rerun", 0, 0);

    r_enable = 1'b1;
    put(0, 1, 1);
    start(0, 1, 64'sh7fff_ffff_ffff_ffff);
`ifdef DOTPROD_SAT_EN
    finish_run(0, 1, 64'sh7fff_ffff_ffff_ffff, "sat", 0, 0);
    chk("sat_ovf", 64'(ovf), 64'd1);
`else
    finish_run(0, 1, 64'sh8000_0000_0000_0000, "wrap", 0, 0);
    chk("wrap_ovf", 64'(ovf), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
